ifu_mem_bridge: RTL and testbench

Instruction-fetch memory bridge that sits directly downstream of the IFU's PC register. It accepts a fetch PC through a valid/ready handshake and issues a single-beat 64-bit AXI-lite-style read for the aligned doubleword. It returns the addressed 32-bit instruction in the low half of a 64-bit `inst64` word, which the IFU consumes. Fetch flushes are handled by discarding in-flight responses without violating bus handshake rules.

---
 rtl/ifu_mem_bridge_if.sv | 36 +++
 rtl/ifu_mem_bridge.sv | 124 ++++++++++++
 tb/tb_ifu_mem_bridge.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_mem_bridge_if.sv
// ifu_mem_bridge_if: fetch handshake plus single-beat read channels of
// ifu_mem_bridge, bundled so the bridge takes one bus port.
//   master modport : bridge view (drives *_o, samples *_i)
//   slave  modport : IFU + memory view (drives *_i, samples *_o)
//   pc_valid_i/pc_i/pc_ready_o/flush_i          : fetch PC handshake
//   inst64_o/inst_valid_o/fetch_err_o           : fetch result
//   araddr_o/arvalid_o/arready_i                : read address channel
//   rdata_i/rresp_i/rvalid_i/rready_o           : read data channel
interface ifu_mem_bridge_if;
   logic        pc_valid_i;
   logic [31:0] pc_i;
   logic        pc_ready_o;
   logic        flush_i;
   logic [63:0] inst64_o;
   logic        inst_valid_o;
   logic        fetch_err_o;
   logic [31:0] araddr_o;
   logic        arvalid_o;
   logic        arready_i;
   logic [63:0] rdata_i;
   logic [1:0]  rresp_i;
   logic        rvalid_i;
   logic        rready_o;

   modport master (
      input  pc_valid_i, pc_i, flush_i, arready_i, rdata_i, rresp_i, rvalid_i,
      output pc_ready_o, inst64_o, inst_valid_o, fetch_err_o, araddr_o, arvalid_o,
             rready_o
   );

   modport slave (
      output pc_valid_i, pc_i, flush_i, arready_i, rdata_i, rresp_i, rvalid_i,
      input  pc_ready_o, inst64_o, inst_valid_o, fetch_err_o, araddr_o, arvalid_o,
             rready_o
   );
endinterface

// File: rtl/ifu_mem_bridge.sv
// ifu_mem_bridge: accepts a fetch PC, issues one 64-bit read for the aligned
// doubleword and returns the addressed 32-bit instruction in inst64_o[31:0].
// Flushes drop in-flight responses while still completing the bus handshakes.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : ifu_mem_bridge_if.master (fetch handshake + read channels)
//   BYPASS_PC : pre-reset PC answered with instruction 0, no bus access
module ifu_mem_bridge #(
   parameter logic [31:0] BYPASS_PC = 32'h7fff_fffc
) (
   input  logic             clk,
   input  logic             rst,
   ifu_mem_bridge_if.master bus
);
   localparam logic [31:0] PC_WORD_MASK = 32'hffff_fffc;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      DROP = 2'd3
   } state_t;

   state_t state_q;
   logic   drop_q;
   logic   pc_hi_q;
   logic   bypass_q;

   logic   pc_take_c;
   logic   is_bypass_c;
   logic   flush_now_c;

   // A PC presented together with a flush is ignored.
   assign pc_take_c   = bus.pc_valid_i && !bus.flush_i;
   // Compare word address only; pc[1:0] does not select anything.
   assign is_bypass_c = ((bus.pc_i ^ BYPASS_PC) & PC_WORD_MASK) == 32'h0;
   // A flush coinciding with arready must still drop the response.
   assign flush_now_c = drop_q || bus.flush_i;

   assign bus.pc_ready_o = (state_q == IDLE);

   // Fetch sequencer with registered bus and result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= IDLE;
         drop_q           <= 1'b0;
         pc_hi_q          <= 1'b0;
         bypass_q         <= 1'b0;
         bus.inst64_o     <= 64'h0;
         bus.inst_valid_o <= 1'b0;
         bus.fetch_err_o  <= 1'b0;
         bus.araddr_o     <= 32'h0;
         bus.arvalid_o    <= 1'b0;
         bus.rready_o     <= 1'b0;
      end else begin
         bus.inst_valid_o <= 1'b0;
         bus.fetch_err_o  <= 1'b0;
         bypass_q         <= 1'b0;

         // Bypass answer is delivered one cycle after acceptance; it never
         // coincides with a bus response since the bus path takes >= 2 cycles.
         if (bypass_q) begin
            bus.inst64_o     <= 64'h0;
            bus.inst_valid_o <= 1'b1;
         end

         unique case (state_q)
            IDLE: begin
               if (pc_take_c) begin
                  if (is_bypass_c) begin
                     bypass_q <= 1'b1;
                  end else begin
                     bus.araddr_o  <= {bus.pc_i[31:3], 3'b000};
                     pc_hi_q       <= bus.pc_i[2];
                     bus.arvalid_o <= 1'b1;
                     state_q       <= ADDR;
                  end
               end
            end

            ADDR: begin
               if (bus.arready_i) begin
                  bus.arvalid_o <= 1'b0;
                  bus.rready_o  <= 1'b1;
                  drop_q        <= flush_now_c;
                  state_q       <= flush_now_c ? DROP : DATA;
               end else if (bus.flush_i) begin
                  drop_q <= 1'b1;
               end
            end

            DATA: begin
               if (bus.rvalid_i) begin
                  bus.rready_o <= 1'b0;
                  state_q      <= IDLE;
                  if (!bus.flush_i) begin
                     bus.inst_valid_o <= 1'b1;
                     if (bus.rresp_i != 2'b00) begin
                        bus.inst64_o    <= 64'h0;
                        bus.fetch_err_o <= 1'b1;
                     end else if (pc_hi_q) begin
                        bus.inst64_o <= {32'h0, bus.rdata_i[63:32]};
                     end else begin
                        bus.inst64_o <= bus.rdata_i;
                     end
                  end
               end else if (bus.flush_i) begin
                  drop_q  <= 1'b1;
                  state_q <= DROP;
               end
            end

            DROP: begin
               if (bus.rvalid_i) begin
                  bus.rready_o <= 1'b0;
                  drop_q       <= 1'b0;
                  state_q      <= IDLE;
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ifu_mem_bridge.sv
// tb_ifu_mem_bridge: table-driven and randomized checks of ifu_mem_bridge
// against a transaction-level expectation model and a delay-programmable
// memory responder.
module tb_ifu_mem_bridge;
   localparam logic [31:0] BYP = 32'h7fff_fffc;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   ifu_mem_bridge_if bus ();

   ifu_mem_bridge #(.BYPASS_PC(BYP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] pc;
      int          ard;
      int          rd;
      logic [63:0] data;
      logic [1:0]  resp;
      int          mode;      // 0 none, 1 flush after accept, 2 flush one cycle later, 3 flush with pc_valid
      bit          exp_pulse;
      logic [63:0] exp_inst;
      bit          exp_err;
      int          exp_lat;
      bit          exp_bus;
      logic [31:0] exp_addr;
   } vec_t;

   typedef struct {
      int          c;
      logic [63:0] inst;
      logic        err;
   } res_t;

   int          n_checks = 0;
   int          n_pass   = 0;
   res_t        res_q[$];
   int          orphan_err = 0;
   logic [63:0] last_inst = 64'h0;

   // responder configuration and bookkeeping
   int          cfg_ard = 0;
   int          cfg_rd  = 0;
   logic [63:0] cfg_data = 64'h0;
   logic [1:0]  cfg_resp = 2'b00;
   int          n_ar = 0;
   int          n_r  = 0;
   logic [31:0] seen_addr = 32'h0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Result monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (bus.inst_valid_o === 1'b1) res_q.push_back('{cyc, bus.inst64_o, bus.fetch_err_o});
      if (bus.fetch_err_o === 1'b1 && bus.inst_valid_o !== 1'b1) orphan_err++;
   end

   // Memory responder: arready after cfg_ard wait cycles, rvalid cfg_rd cycles after the AR handshake.
   initial begin
      int sph;
      int wcnt;
      sph = 0;
      wcnt = 0;
      bus.arready_i = 1'b0;
      bus.rvalid_i  = 1'b0;
      bus.rdata_i   = 64'h0;
      bus.rresp_i   = 2'b00;
      forever begin
         @(posedge clk);
         #2;
         if (rst) begin
            bus.arready_i = 1'b0;
            bus.rvalid_i  = 1'b0;
            sph = 0;
         end else begin
            case (sph)
               4: begin bus.rvalid_i = 1'b0; n_r++; sph = 0; end
               2: begin bus.arready_i = 1'b0; n_ar++; wcnt = cfg_rd; sph = 3; end
               1: begin
                  check("arvalid_hold", 64'(bus.arvalid_o), 64'h1);
                  check("araddr_hold", 64'(bus.araddr_o), 64'(seen_addr));
               end
               default: ;
            endcase
            if (sph == 0 && bus.arvalid_o === 1'b1) begin
               seen_addr = bus.araddr_o;
               wcnt = cfg_ard;
               sph = 1;
            end
            if (sph == 1) begin
               if (wcnt == 0) begin bus.arready_i = 1'b1; sph = 2; end
               else wcnt--;
            end
            if (sph == 3) begin
               if (wcnt == 0) begin
                  check("rready_at_rvalid", 64'(bus.rready_o), 64'h1);
                  bus.rvalid_i = 1'b1;
                  bus.rdata_i  = cfg_data;
                  bus.rresp_i  = cfg_resp;
                  sph = 4;
               end else wcnt--;
            end
         end
      end
   end

   // Expected outcome of one fetch, stated at transaction level.
   function automatic vec_t model(input logic [31:0] pc, input int ard, input int rd,
                                  input logic [63:0] data, input logic [1:0] resp, input int mode);
      vec_t v;
      v = '{pc, ard, rd, data, resp, mode, 1'b0, 64'h0, 1'b0, 0, 1'b0, 32'h0};
      if (mode == 3) return v;
      if (pc[31:2] == BYP[31:2]) begin
         v.exp_pulse = 1'b1;
         v.exp_lat   = 1;
         return v;
      end
      v.exp_bus  = 1'b1;
      v.exp_addr = pc & 32'hffff_fff8;
      if (mode != 0) return v;
      v.exp_pulse = 1'b1;
      v.exp_lat   = 2 + ard + rd;
      v.exp_err   = (resp != 2'b00);
      if (v.exp_err) v.exp_inst = 64'h0;
      else if (pc[2]) v.exp_inst = {32'h0, data[63:32]};
      else v.exp_inst = data;
      return v;
   endfunction

   task automatic run_vec(input vec_t v, input string tag);
      int acc;
      int n_ar0;
      int n_r0;
      int nres0;
      int budget;
      int pulses;
      budget = 0;
      while (bus.pc_ready_o !== 1'b1 && budget < 50) begin step(); budget++; end
      check({tag, ".ready_before"}, 64'(bus.pc_ready_o), 64'h1);
      cfg_ard  = v.ard;
      cfg_rd   = v.rd;
      cfg_data = v.data;
      cfg_resp = v.resp;
      n_ar0 = n_ar;
      n_r0  = n_r;
      nres0 = res_q.size();
      bus.pc_valid_i = 1'b1;
      bus.pc_i       = v.pc;
      bus.flush_i    = (v.mode == 3);
      step();
      acc = cyc;
      bus.pc_valid_i = 1'b0;
      bus.flush_i    = 1'b0;
      bus.pc_i       = $urandom;
      check({tag, ".arvalid_at_accept"}, 64'(bus.arvalid_o), 64'(v.exp_bus));
      check({tag, ".pc_ready_at_accept"}, 64'(bus.pc_ready_o), 64'(!v.exp_bus));
      if (v.mode == 1) begin
         bus.flush_i = 1'b1; step(); bus.flush_i = 1'b0;
      end else if (v.mode == 2) begin
         step(); bus.flush_i = 1'b1; step(); bus.flush_i = 1'b0;
      end
      budget = 0;
      while (bus.pc_ready_o !== 1'b1 && budget < 100) begin step(); budget++; end
      if (budget >= 100) check({tag, ".timeout"}, 64'(budget), 64'h0);
      repeat (3) step();
      pulses = res_q.size() - nres0;
      check({tag, ".pulses"}, 64'(pulses), 64'(v.exp_pulse));
      if (v.exp_pulse && pulses >= 1) begin
         check({tag, ".inst64"}, res_q[nres0].inst, v.exp_inst);
         check({tag, ".err"}, 64'(res_q[nres0].err), 64'(v.exp_err));
         check({tag, ".latency"}, 64'(res_q[nres0].c - acc), 64'(v.exp_lat));
         last_inst = v.exp_inst;
      end
      check({tag, ".inst64_hold"}, bus.inst64_o, last_inst);
      check({tag, ".ar_count"}, 64'(n_ar - n_ar0), 64'(v.exp_bus));
      check({tag, ".r_count"}, 64'(n_r - n_r0), 64'(v.exp_bus));
      if (v.exp_bus) check({tag, ".araddr"}, 64'(seen_addr), 64'(v.exp_addr));
      check({tag, ".err_without_valid"}, 64'(orphan_err), 64'h0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, ".inst64"}, bus.inst64_o, 64'h0);
      check({tag, ".inst_valid"}, 64'(bus.inst_valid_o), 64'h0);
      check({tag, ".fetch_err"}, 64'(bus.fetch_err_o), 64'h0);
      check({tag, ".arvalid"}, 64'(bus.arvalid_o), 64'h0);
      check({tag, ".rready"}, 64'(bus.rready_o), 64'h0);
      check({tag, ".araddr"}, 64'(bus.araddr_o), 64'h0);
      check({tag, ".pc_ready"}, 64'(bus.pc_ready_o), 64'h1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got cycle %0d expected completion", cyc);
      $fatal(1);
   end

   initial begin
      vec_t tbl[10];
      vec_t v;
      int   nres0;
      int   r;

      tbl[0] = '{32'h8000_0000, 0, 0, 64'h1111_1111_0000_0413, 2'b00, 0,
                 1'b1, 64'h1111_1111_0000_0413, 1'b0, 2, 1'b1, 32'h8000_0000};
      tbl[1] = '{32'h8000_0004, 0, 0, 64'h1111_1111_0000_0413, 2'b00, 0,
                 1'b1, 64'h0000_0000_1111_1111, 1'b0, 2, 1'b1, 32'h8000_0000};
      tbl[2] = '{32'h8000_0010, 3, 2, 64'hdead_beef_cafe_f00d, 2'b00, 0,
                 1'b1, 64'hdead_beef_cafe_f00d, 1'b0, 7, 1'b1, 32'h8000_0010};
      tbl[3] = '{32'h8000_0020, 2, 1, 64'h0123_4567_89ab_cdef, 2'b00, 1,
                 1'b0, 64'h0, 1'b0, 0, 1'b1, 32'h8000_0020};
      tbl[4] = '{32'h8000_002c, 0, 2, 64'h7654_3210_fedc_ba98, 2'b00, 2,
                 1'b0, 64'h0, 1'b0, 0, 1'b1, 32'h8000_0028};
      tbl[5] = '{32'h8000_0008, 0, 0, 64'h2222_2222_3333_3333, 2'b00, 0,
                 1'b1, 64'h2222_2222_3333_3333, 1'b0, 2, 1'b1, 32'h8000_0008};
      tbl[6] = '{32'h8000_0030, 1, 1, 64'hffff_ffff_ffff_ffff, 2'b10, 0,
                 1'b1, 64'h0, 1'b1, 4, 1'b1, 32'h8000_0030};
      tbl[7] = '{32'h7fff_fffc, 0, 0, 64'h9999_9999_9999_9999, 2'b00, 0,
                 1'b1, 64'h0, 1'b0, 1, 1'b0, 32'h0};
      tbl[8] = '{32'h8000_0040, 0, 0, 64'h4444_4444_4444_4444, 2'b00, 3,
                 1'b0, 64'h0, 1'b0, 0, 1'b0, 32'h0};
      tbl[9] = '{32'h8000_0048, 0, 1, 64'ha5a5_a5a5_5a5a_5a5a, 2'b00, 0,
                 1'b1, 64'ha5a5_a5a5_5a5a_5a5a, 1'b0, 3, 1'b1, 32'h8000_0048};

      // Reset, with a request presented that must be ignored.
      bus.pc_valid_i = 1'b1;
      bus.pc_i       = 32'h8000_0100;
      bus.flush_i    = 1'b0;
      rst = 1'b1;
      repeat (3) step();
      check_reset_vals("reset");
      rst = 1'b0;
      bus.pc_valid_i = 1'b0;
      step();
      check("reset.no_request_taken", 64'(bus.arvalid_o), 64'h0);

      for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

      // Reset while waiting in DATA.
      cfg_ard = 0;
      cfg_rd  = 5;
      cfg_data = 64'h5555_6666_7777_8888;
      cfg_resp = 2'b00;
      nres0 = res_q.size();
      bus.pc_valid_i = 1'b1;
      bus.pc_i       = 32'h8000_0050;
      step();
      bus.pc_valid_i = 1'b0;
      step();
      check("midrst.rready_in_data", 64'(bus.rready_o), 64'h1);
      rst = 1'b1;
      step();
      check_reset_vals("midrst");
      rst = 1'b0;
      repeat (8) step();
      check("midrst.no_pulse", 64'(res_q.size() - nres0), 64'h0);
      last_inst = 64'h0;
      run_vec(model(32'h8000_0060, 1, 0, 64'h0bad_f00d_1234_5678, 2'b00, 0), "after_rst");

      // Randomized fetches against the model.
      for (int i = 0; i < 40; i++) begin
         logic [31:0] pc;
         r = int'($urandom_range(0, 7));
         pc = (r == 0) ? (BYP | 32'($urandom_range(0, 3))) : {1'b1, 31'($urandom)};
         v = model(pc, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   {$urandom, $urandom}, ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
         run_vec(v, $sformatf("rnd%0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
